// File: rtl/riscv_core_pkg.sv
// Shared RV64I core definitions: datapath width, writeback result-source and load funct3 encodings.
package riscv_core_pkg;

  localparam int XLEN = 64;

  typedef enum logic [1:0] {
    RES_ALU  = 2'b00,
    RES_LOAD = 2'b01,
    RES_PC4  = 2'b10
  } result_src_e;

  typedef enum logic [2:0] {
    F3_LB  = 3'b000,
    F3_LH  = 3'b001,
    F3_LW  = 3'b010,
    F3_LD  = 3'b011,
    F3_LBU = 3'b100,
    F3_LHU = 3'b101,
    F3_LWU = 3'b110
  } load_f3_e;

  // True when the load size cannot be served at this byte offset, or funct3 is not a load.
  function automatic logic ld_fault(input logic [2:0] funct3, input logic [2:0] offset);
    case (funct3)
      F3_LB, F3_LBU: ld_fault = 1'b0;
      F3_LH, F3_LHU: ld_fault = offset[0];
      F3_LW, F3_LWU: ld_fault = |offset[1:0];
      F3_LD:         ld_fault = |offset;
      default:       ld_fault = 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/riscv_core_wb_ldext.sv
// Load-data extraction: picks the addressed bytes from an aligned doubleword and sign/zero extends them.
module riscv_core_wb_ldext
  import riscv_core_pkg::*;
(
  input  logic [XLEN-1:0] i_raw,
  input  logic [2:0]      i_offset,
  input  logic [2:0]      i_funct3,
  output logic [XLEN-1:0] o_data,
  output logic            o_fault
);

  logic [XLEN-1:0] w_shift;

  // Little-endian: the addressed byte lands in bits [7:0] after the shift.
  assign w_shift = i_raw >> {i_offset, 3'b000};

  always_comb begin
    o_data = w_shift;
    case (i_funct3)
      F3_LB:   o_data = {{(XLEN-8){w_shift[7]}},   w_shift[7:0]};
      F3_LH:   o_data = {{(XLEN-16){w_shift[15]}}, w_shift[15:0]};
      F3_LW:   o_data = {{(XLEN-32){w_shift[31]}}, w_shift[31:0]};
      F3_LBU:  o_data = {{(XLEN-8){1'b0}},         w_shift[7:0]};
      F3_LHU:  o_data = {{(XLEN-16){1'b0}},        w_shift[15:0]};
      F3_LWU:  o_data = {{(XLEN-32){1'b0}},        w_shift[31:0]};
      default: o_data = w_shift;
    endcase
  end

  assign o_fault = ld_fault(i_funct3, i_offset);

endmodule

// File: rtl/riscv_core_wb.sv
// RV64I writeback stage: MEM/WB register, result select, load extraction and RF write port.
// Optional retire counter compiled in with RISCV_CORE_WB_RETIRE_CNT_EN.
module riscv_core_wb
  import riscv_core_pkg::*;
#(
  parameter int XLEN_P = XLEN
`ifdef RISCV_CORE_WB_RETIRE_CNT_EN
  ,
  parameter int CNT_W  = 64
`endif
) (
  input  logic              i_wb_clk,
  input  logic              i_wb_rst_n,
  input  logic              i_wb_valid,
  input  logic              i_wb_stall,
  input  logic              i_wb_flush,
  input  logic              i_wb_regwrite,
  input  logic [4:0]        i_wb_rd,
  input  logic [1:0]        i_wb_result_src,
  input  logic [2:0]        i_wb_funct3,
  input  logic [XLEN_P-1:0] i_wb_alu_result,
  input  logic [XLEN_P-1:0] i_wb_pc_plus4,
  input  logic [XLEN_P-1:0] i_wb_load_data,
  output logic              o_wb_we3,
  output logic [4:0]        o_wb_a3,
  output logic [XLEN_P-1:0] o_wb_wd3,
  output logic              o_wb_valid,
  output logic              o_wb_ld_fault
`ifdef RISCV_CORE_WB_RETIRE_CNT_EN
  ,
  output logic [CNT_W-1:0]  o_wb_retire_cnt
`endif
);

  logic [XLEN_P-1:0] w_ld_data;
  logic              w_ext_fault;
  logic              w_is_load;
  logic              w_fault;
  logic [XLEN_P-1:0] w_result;
  logic              w_capture;

  logic              r_we3;
  logic [4:0]        r_a3;
  logic [XLEN_P-1:0] r_wd3;
  logic              r_valid;
  logic              r_fault;

  riscv_core_wb_ldext u_ldext (
    .i_raw    (i_wb_load_data),
    .i_offset (i_wb_alu_result[2:0]),
    .i_funct3 (i_wb_funct3),
    .o_data   (w_ld_data),
    .o_fault  (w_ext_fault)
  );

  // funct3 is meaningless for non-loads, so the fault is gated by result source.
  assign w_is_load = (i_wb_result_src == RES_LOAD);
  assign w_fault   = w_is_load & w_ext_fault;
  assign w_capture = !i_wb_flush & !i_wb_stall;

  always_comb begin
    w_result = i_wb_alu_result;
    case (i_wb_result_src)
      RES_LOAD: w_result = w_ld_data;
      RES_PC4:  w_result = i_wb_pc_plus4;
      default:  w_result = i_wb_alu_result;
    endcase
  end

  always_ff @(posedge i_wb_clk or negedge i_wb_rst_n) begin
    if (!i_wb_rst_n) begin
      r_we3   <= 1'b0;
      r_a3    <= '0;
      r_wd3   <= '0;
      r_valid <= 1'b0;
      r_fault <= 1'b0;
    end else if (i_wb_flush) begin
      r_we3   <= 1'b0;
      r_valid <= 1'b0;
      r_fault <= 1'b0;
    end else if (!i_wb_stall) begin
      r_valid <= i_wb_valid;
      r_fault <= i_wb_valid & w_fault;
      r_we3   <= i_wb_valid & i_wb_regwrite & !w_fault & (i_wb_rd != 5'd0);
      // Bubbles leave a3/wd3 untouched; only we3 qualifies them.
      if (i_wb_valid) begin
        r_a3  <= i_wb_rd;
        r_wd3 <= w_result;
      end
    end
  end

`ifdef RISCV_CORE_WB_RETIRE_CNT_EN
  logic [CNT_W-1:0] r_retire_cnt;

  always_ff @(posedge i_wb_clk or negedge i_wb_rst_n) begin
    if (!i_wb_rst_n) begin
      r_retire_cnt <= '0;
    end else if (w_capture & i_wb_valid & !w_fault) begin
      r_retire_cnt <= r_retire_cnt + 1'b1;
    end
  end

  assign o_wb_retire_cnt = r_retire_cnt;
`else
  logic w_capture_unused;
  assign w_capture_unused = w_capture;
`endif

  assign o_wb_we3      = r_we3;
  assign o_wb_a3       = r_a3;
  assign o_wb_wd3      = r_wd3;
  assign o_wb_valid    = r_valid;
  assign o_wb_ld_fault = r_fault;

endmodule

// File: tb/tb_riscv_core_wb.sv
// Directed scoreboard bench for riscv_core_wb; retire-count checks follow RISCV_CORE_WB_RETIRE_CNT_EN.
module tb_riscv_core_wb;

  logic        clk;
  logic        rst_n;
  logic        valid, stall, flush, regwrite;
  logic [4:0]  rd;
  logic [1:0]  src;
  logic [2:0]  f3;
  logic [63:0] alu, pc4, ld;
  logic        we3;
  logic [4:0]  a3;
  logic [63:0] wd3;
  logic        o_valid;
  logic        fault;
`ifdef RISCV_CORE_WB_RETIRE_CNT_EN
  logic [63:0] cnt;
`endif

  riscv_core_wb dut (
    .i_wb_clk        (clk),
    .i_wb_rst_n      (rst_n),
    .i_wb_valid      (valid),
    .i_wb_stall      (stall),
    .i_wb_flush      (flush),
    .i_wb_regwrite   (regwrite),
    .i_wb_rd         (rd),
    .i_wb_result_src (src),
    .i_wb_funct3     (f3),
    .i_wb_alu_result (alu),
    .i_wb_pc_plus4   (pc4),
    .i_wb_load_data  (ld),
    .o_wb_we3        (we3),
    .o_wb_a3         (a3),
    .o_wb_wd3        (wd3),
    .o_wb_valid      (o_valid),
    .o_wb_ld_fault   (fault)
`ifdef RISCV_CORE_WB_RETIRE_CNT_EN
    ,
    .o_wb_retire_cnt (cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register file model committing on the falling edge.
  logic [63:0] rf [32];
  always @(negedge clk) begin
    if (we3 && a3 != 5'd0) rf[a3] <= wd3;
  end

  typedef struct {
    logic        we3;
    logic [4:0]  a3;
    logic [63:0] wd3;
    logic        valid;
    logic        fault;
    logic [63:0] cnt;
  } exp_t;

  exp_t sb[$];
  exp_t cur;
  int   n_err;
  int   n_chk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_chk++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  function automatic logic m_fault(input logic [2:0] fn, input logic [2:0] off);
    case (fn)
      3'd1, 3'd5: m_fault = (off % 2) != 0;
      3'd2, 3'd6: m_fault = (off % 4) != 0;
      3'd3:       m_fault = off != 0;
      3'd7:       m_fault = 1'b1;
      default:    m_fault = 1'b0;
    endcase
  endfunction

  function automatic logic [63:0] m_load(input logic [63:0] d, input logic [2:0] off, input logic [2:0] fn);
    logic [7:0] b [8];
    int o;
    for (int i = 0; i < 8; i++) b[i] = d[8*i +: 8];
    o = int'(off);
    case (fn)
      3'd0: m_load = {{56{b[o][7]}}, b[o]};
      3'd1: m_load = {{48{b[o+1][7]}}, b[o+1], b[o]};
      3'd2: m_load = {{32{b[o+3][7]}}, b[o+3], b[o+2], b[o+1], b[o]};
      3'd4: m_load = {56'd0, b[o]};
      3'd5: m_load = {48'd0, b[o+1], b[o]};
      3'd6: m_load = {32'd0, b[o+3], b[o+2], b[o+1], b[o]};
      default: m_load = d;
    endcase
  endfunction

  task automatic compare_outputs(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, 64'd1, 64'd0);
      return;
    end
    e = sb.pop_front();
    chk({tag, "_valid"}, {63'd0, o_valid}, {63'd0, e.valid});
    chk({tag, "_we3"},   {63'd0, we3},     {63'd0, e.we3});
    chk({tag, "_fault"}, {63'd0, fault},   {63'd0, e.fault});
    if (e.valid && !e.fault) begin
      chk({tag, "_a3"},  {59'd0, a3}, {59'd0, e.a3});
      chk({tag, "_wd3"}, wd3, e.wd3);
    end
`ifdef RISCV_CORE_WB_RETIRE_CNT_EN
    chk({tag, "_cnt"}, cnt, e.cnt);
`endif
    $display("txn %s: valid=%0b we3=%0b a3=%0d wd3=%h fault=%0b", tag, o_valid, we3, a3, wd3, fault);
  endtask

  task automatic step(input string tag, input logic v, input logic st, input logic fl, input logic rw,
                      input logic [4:0] r, input logic [1:0] s, input logic [2:0] fn,
                      input logic [63:0] a, input logic [63:0] p, input logic [63:0] d);
    exp_t nx;
    logic flt;
    valid = v; stall = st; flush = fl; regwrite = rw;
    rd = r; src = s; f3 = fn; alu = a; pc4 = p; ld = d;
    nx  = cur;
    flt = (s == 2'b01) && m_fault(fn, a[2:0]);
    if (fl) begin
      nx.valid = 1'b0; nx.we3 = 1'b0; nx.fault = 1'b0;
    end else if (!st) begin
      nx.valid = v;
      nx.fault = v & flt;
      nx.we3   = v & rw & !flt & (r != 5'd0);
      if (v) begin
        nx.a3  = r;
        nx.wd3 = (s == 2'b01) ? m_load(d, a[2:0], fn) : (s == 2'b10) ? p : a;
        if (!flt) nx.cnt = cur.cnt + 64'd1;
      end
    end
    cur = nx;
    sb.push_back(nx);
    @(posedge clk);
    #1;
    compare_outputs(tag);
  endtask

  initial begin
    logic [63:0] rnd;
    logic [63:0] cnt_before;
    n_err = 0; n_chk = 0;
    rst_n = 1'b1;
    valid = 0; stall = 0; flush = 0; regwrite = 0;
    rd = 0; src = 0; f3 = 0; alu = 0; pc4 = 0; ld = 0;
    cur = '{we3: 1'b0, a3: 5'd0, wd3: 64'd0, valid: 1'b0, fault: 1'b0, cnt: 64'd0};
    for (int i = 0; i < 32; i++) rf[i] = 64'd0;

    #2 rst_n = 1'b0;
    @(posedge clk); #1;
    chk("rst_we3",   {63'd0, we3},     64'd0);
    chk("rst_a3",    {59'd0, a3},      64'd0);
    chk("rst_wd3",   wd3,              64'd0);
    chk("rst_valid", {63'd0, o_valid}, 64'd0);
    chk("rst_fault", {63'd0, fault},   64'd0);
`ifdef RISCV_CORE_WB_RETIRE_CNT_EN
    chk("rst_cnt", cnt, 64'd0);
`endif
    @(negedge clk); rst_n = 1'b1; #1;

    // ALU writeback and same-cycle RF visibility
    step("alu_x5", 1, 0, 0, 1, 5'd5, 2'b00, 3'd0, 64'h1234, 64'h0, 64'h0);
    @(negedge clk); #1;
    chk("rf_x5", rf[5], 64'h1234);

    step("lb_sext", 1, 0, 0, 1, 5'd6, 2'b01, 3'd0, 64'h1007, 64'h0, 64'h80FF_0000_0000_0000);
    chk("lb_lit", wd3, 64'hFFFF_FFFF_FFFF_FF80);
    step("lbu_zext", 1, 0, 0, 1, 5'd6, 2'b01, 3'd4, 64'h1007, 64'h0, 64'h80FF_0000_0000_0000);
    chk("lbu_lit", wd3, 64'h80);

`ifdef RISCV_CORE_WB_RETIRE_CNT_EN
    cnt_before = cnt;
`else
    cnt_before = 64'd0;
`endif
    step("lw_misal", 1, 0, 0, 1, 5'd7, 2'b01, 3'd2, 64'h2002, 64'h0, 64'h1122_3344_5566_7788);
`ifdef RISCV_CORE_WB_RETIRE_CNT_EN
    chk("lw_misal_cnt_hold", cnt, cnt_before);
`endif
    step("x0_write", 1, 0, 0, 1, 5'd0, 2'b00, 3'd0, 64'hDEAD, 64'h0, 64'h0);

    step("lh_off6",  1, 0, 0, 1, 5'd8,  2'b01, 3'd1, 64'h06, 64'h0, 64'h8765_4321_0FED_CBA9);
    step("lhu_off6", 1, 0, 0, 1, 5'd8,  2'b01, 3'd5, 64'h06, 64'h0, 64'h8765_4321_0FED_CBA9);
    step("lw_off4",  1, 0, 0, 1, 5'd9,  2'b01, 3'd2, 64'h04, 64'h0, 64'h8765_4321_0FED_CBA9);
    step("lwu_off4", 1, 0, 0, 1, 5'd9,  2'b01, 3'd6, 64'h04, 64'h0, 64'h8765_4321_0FED_CBA9);
    step("ld_off0",  1, 0, 0, 1, 5'd10, 2'b01, 3'd3, 64'h40, 64'h0, 64'h8765_4321_0FED_CBA9);
    step("ld_off4",  1, 0, 0, 1, 5'd10, 2'b01, 3'd3, 64'h44, 64'h0, 64'h8765_4321_0FED_CBA9);
    step("lh_off1",  1, 0, 0, 1, 5'd10, 2'b01, 3'd1, 64'h41, 64'h0, 64'h8765_4321_0FED_CBA9);
    step("f3_111",   1, 0, 0, 1, 5'd11, 2'b01, 3'd7, 64'h00, 64'h0, 64'h1);
    step("pc4",      1, 0, 0, 1, 5'd1,  2'b10, 3'd7, 64'h13, 64'h8000_0004, 64'h0);
    step("src11",    1, 0, 0, 1, 5'd2,  2'b11, 3'd7, 64'hABCD, 64'h99, 64'h77);
    step("no_rw",    1, 0, 0, 0, 5'd12, 2'b00, 3'd0, 64'h42, 64'h0, 64'h0);
    step("bubble",   0, 0, 0, 1, 5'd13, 2'b00, 3'd0, 64'h43, 64'h0, 64'h0);

    for (int i = 0; i < 8; i++) begin
      rnd = {$urandom, $urandom};
      step("rand_ld", 1, 0, 0, 1, 5'($urandom_range(1, 31)), 2'b01, 3'($urandom_range(0, 6)),
           64'($urandom_range(0, 7)), 64'h0, rnd);
    end

    // Stall holds everything, then flush beats stall and valid
    step("cap_x3", 1, 0, 0, 1, 5'd3, 2'b00, 3'd0, 64'h55, 64'h0, 64'h0);
    for (int i = 0; i < 3; i++) begin
      step("stall", 1, 1, 0, 1, 5'd4, 2'b00, 3'd0, 64'h66, 64'h0, 64'h0);
      chk("stall_a3",  {59'd0, a3}, 64'd3);
      chk("stall_wd3", wd3, 64'h55);
    end
    step("flush_stall", 1, 1, 1, 1, 5'd4, 2'b00, 3'd0, 64'h77, 64'h0, 64'h0);
    step("post_flush", 1, 0, 0, 1, 5'd7, 2'b00, 3'd0, 64'h99, 64'h0, 64'h0);

    // Asynchronous reset between edges while we3 is high
    #2 rst_n = 1'b0;
    #1;
    chk("arst_we3",   {63'd0, we3},     64'd0);
    chk("arst_a3",    {59'd0, a3},      64'd0);
    chk("arst_wd3",   wd3,              64'd0);
    chk("arst_valid", {63'd0, o_valid}, 64'd0);
    chk("arst_fault", {63'd0, fault},   64'd0);
`ifdef RISCV_CORE_WB_RETIRE_CNT_EN
    chk("arst_cnt", cnt, 64'd0);
`endif
    cur = '{we3: 1'b0, a3: 5'd0, wd3: 64'd0, valid: 1'b0, fault: 1'b0, cnt: 64'd0};
    #2 rst_n = 1'b1;
    step("after_rst", 1, 0, 0, 1, 5'd9, 2'b00, 3'd0, 64'h5A5A, 64'h0, 64'h0);

    chk("sb_drained", 64'(sb.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
